// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - register offsets, response codes and hex-to-segment decode for the FND slave
package fnd_pkg;

   localparam logic [3:0] FND_CTRL  = 4'h0;
   localparam logic [3:0] FND_VALUE = 4'h4;
   localparam logic [3:0] FND_DP    = 4'h8;
   localparam logic [3:0] FND_BLANK = 4'hC;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Segment pattern for one hex digit; bit 0 = a .. bit 6 = g, active-low.
   function automatic logic [6:0] hexdec(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/fnd_scan.sv
// rtl/fnd_scan.sv - prescaled digit scanner driving the active-low 4-digit display
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic [3:0]  blank,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [1:0]    d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         d     <= 2'd0;
         an_n  <= 4'hF;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         // The scan keeps running while disabled so re-enabling is glitch-free.
         if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            d   <= d + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (en && !blank[d]) begin
            an_n  <= ~(4'b0001 << d);
            seg_n <= hexdec(value[{d, 2'b00} +: 4]);
            dp_n  <= ~dp[d];
         end else begin
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axil_fnd_slave.sv
// rtl/axil_fnd_slave.sv - AXI4-Lite register slave for the FND seven-segment peripheral
module axil_fnd_slave
   import fnd_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int SCAN_DIV           = 100000
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [6:0]                        seg_n,
   output logic                              dp_n,
   output logic [3:0]                        an_n
);

   logic [31:0] regs [4];
   logic        wr_accept;
   logic        rd_accept;
   logic        unused_ok;

   assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
   assign rd_accept = S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;

   assign S_AXI_BRESP = AXI_RESP_OKAY;
   assign S_AXI_RRESP = AXI_RESP_OKAY;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         for (int r = 0; r < 4; r++) regs[r] <= '0;
      end else begin
         S_AXI_AWREADY <= wr_accept;
         S_AXI_WREADY  <= wr_accept;
         if (wr_accept) begin
            for (int b = 0; b < 4; b++)
               if (S_AXI_WSTRB[b]) regs[S_AXI_AWADDR[3:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end

         if (S_AXI_AWREADY) S_AXI_BVALID <= 1'b1;
         else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;

         // RDATA samples pre-write contents when a write lands on the same edge.
         S_AXI_ARREADY <= rd_accept;
         if (rd_accept) S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];

         if (S_AXI_ARREADY) S_AXI_RVALID <= 1'b1;
         else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      end
   end

   fnd_scan #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan (
      .clk   (ACLK),
      .rst   (ARESET),
      .en    (regs[FND_CTRL[3:2]][0]),
      .value (regs[FND_VALUE[3:2]][15:0]),
      .dp    (regs[FND_DP[3:2]][3:0]),
      .blank (regs[FND_BLANK[3:2]][3:0]),
      .seg_n (seg_n),
      .dp_n  (dp_n),
      .an_n  (an_n)
   );

endmodule

// File: tb/tb_axil_fnd_slave.sv
// tb/tb_axil_fnd_slave.sv - self-checking bench for axil_fnd_slave
module tb_axil_fnd_slave;

   localparam int SCAN = 4;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;
   logic [31:0] model [4];
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   axil_fnd_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4),
      .SCAN_DIV(SCAN)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      while (S_AXI_AWREADY !== 1'b1 && n < 20) begin
         @(posedge ACLK); #1; n++;
      end
      chk("aw_w_handshake", {31'd0, S_AXI_AWREADY & S_AXI_WREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      chk("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
      model_write(a, d, s);
      if (S_AXI_BREADY) begin
         @(posedge ACLK); #1;
      end
   endtask

   task automatic axi_read(input logic [3:0] a, input string tag);
      int n = 0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      while (S_AXI_ARREADY !== 1'b1 && n < 20) begin
         @(posedge ACLK); #1; n++;
      end
      chk("ar_handshake", {31'd0, S_AXI_ARREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      chk("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
      chk(tag, S_AXI_RDATA, model[a[3:2]]);
      chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
      @(posedge ACLK); #1;
   endtask

   // Output seen after edge k reflects digit index reached after edge k-1.
   task automatic check_display(input string tag);
      int dd;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      dd = ((cyc - 1) / SCAN) % 4;
      if (model[0][0] && !model[3][dd]) begin
         ea = ~(4'b0001 << dd);
         es = hex_tab[model[1][4*dd +: 4]];
         ed = ~model[2][dd];
      end else begin
         ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end
      chk({tag, "_an"}, {28'd0, an_n}, {28'd0, ea});
      chk({tag, "_seg"}, {25'd0, seg_n}, {25'd0, es});
      chk({tag, "_dp"}, {31'd0, dp_n}, {31'd0, ed});
   endtask

   task automatic run_display(input int n, input string tag);
      repeat (n) begin
         @(posedge ACLK); #1;
         check_display(tag);
      end
   endtask

   initial begin
      int n;
      logic [31:0] old;
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b1;
      for (int r = 0; r < 4; r++) model[r] = '0;
      #1;
      chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
      chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
      chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
      chk("rst_rdata", S_AXI_RDATA, 32'd0);
      chk("rst_an", {28'd0, an_n}, 32'hF);
      chk("rst_seg", {25'd0, seg_n}, 32'h7F);
      chk("rst_dp", {31'd0, dp_n}, 32'd1);
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      run_display(6, "disabled");

      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      axi_write(4'h8, 32'h3, 4'hF);
      axi_write(4'hC, 32'h4, 4'hF);
      axi_read(4'h0, "rd_reg0");
      axi_read(4'h5, "rd_reg1");
      axi_read(4'h8, "rd_reg2");
      axi_read(4'hF, "rd_reg3");

      axi_write(4'h4, 32'h0, 4'hF);
      axi_write(4'h4, 32'hFFFF_FFFF, 4'b0010);
      chk("strb_model", model[1], 32'h0000_FF00);
      axi_read(4'h4, "rd_strb");

      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h1234, 4'hF);
      axi_write(4'h8, 32'h0, 4'hF);
      axi_write(4'hC, 32'h0, 4'hF);
      run_display(34, "scan1234");
      axi_write(4'hC, 32'h4, 4'hF);
      axi_write(4'h8, 32'h1, 4'hF);
      run_display(34, "blank_dp");

      // Simultaneous write and read of VALUE: read must return pre-write contents.
      old = model[1];
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hCAFE_5678; S_AXI_WSTRB = 4'hF;
      S_AXI_ARADDR = 4'h4;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (S_AXI_AWREADY !== 1'b1 && n < 20) begin
         @(posedge ACLK); #1; n++;
      end
      chk("sim_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
      chk("sim_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      chk("sim_rdata_old", S_AXI_RDATA, old);
      chk("sim_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      model_write(4'h4, 32'hCAFE_5678, 4'hF);
      @(posedge ACLK); #1;
      axi_read(4'h4, "sim_rd_new");

      // Write response back-pressure.
      S_AXI_BREADY = 1'b0;
      axi_write(4'h8, 32'h0000_000A, 4'hF);
      S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h0000_0005; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      repeat (4) begin
         @(posedge ACLK); #1;
         chk("hold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
         chk("hold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      end
      S_AXI_BREADY = 1'b1;
      axi_write(4'hC, 32'h0000_0005, 4'hF);
      axi_read(4'h8, "hold_rd2");
      axi_read(4'hC, "hold_rd3");

      repeat (40) begin
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         a = 4'($urandom_range(0, 15));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         axi_write(a, d, s);
         a = 4'($urandom_range(0, 15));
         axi_read(a, "rand_rd");
      end
      repeat (4) begin
         axi_write(4'h0, {$urandom_range(0, 1) == 0 ? 32'h0 : 32'h1}, 4'hF);
         axi_write(4'h4, $urandom, 4'hF);
         axi_write(4'h8, $urandom, 4'hF);
         axi_write(4'hC, $urandom, 4'hF);
         run_display(18, "rand_disp");
      end

      // Reset with a read response still pending.
      S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (S_AXI_ARREADY !== 1'b1 && n < 20) begin
         @(posedge ACLK); #1; n++;
      end
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      chk("pend_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
      @(posedge ACLK); #1;
      chk("pend_rvalid_hold", {31'd0, S_AXI_RVALID}, 32'd1);
      chk("pend_rdata_hold", S_AXI_RDATA, model[1]);
      ARESET = 1'b1;
      #1;
      chk("arst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
      chk("arst_an", {28'd0, an_n}, 32'hF);
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      S_AXI_RREADY = 1'b1;
      for (int r = 0; r < 4; r++) model[r] = '0;
      axi_read(4'h0, "post_rst0");
      axi_read(4'h4, "post_rst1");
      axi_read(4'h8, "post_rst2");
      axi_read(4'hC, "post_rst3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
